// File: rtl/boa_mul_iterative.sv
// boa_mul_iterative
//   Multi-cycle shift-add multiplier, radix 2^STEP. It accepts any mix of signed
//   and unsigned operands and produces the full 2*WIDTH-bit product, which covers
//   MUL/MULH/MULHSU/MULHU. It talks to the execute stall logic through a
//   start/busy/done handshake.
//
//   Parameters:
//     WIDTH  operand width; the product is 2*WIDTH bits wide.
//     STEP   multiplier bits consumed per cycle. WIDTH must be a multiple of STEP.
//
//   Ports:
//     clk    pipeline clock; all state changes on posedge.
//     rst_n  synchronous reset, active low.
//     start  request. It is accepted only while busy==0.
//     u_lhs  lhs is unsigned.
//     u_rhs  rhs is unsigned.
//     lhs    multiplicand, sampled on the accept edge.
//     rhs    multiplier, sampled on the accept edge.
//     busy   an operation is in progress, and start is ignored.
//     done   one-cycle pulse that marks res as valid.
//     res    product. It holds its value until the next done.
//
//   Configuration:
//     BOA_MUL_EARLY_EXIT_EN  When defined, the run ends as soon as the remaining
//                            multiplier bits are all zero. When undefined, the
//                            latency is fixed at WIDTH/STEP cycles.
module boa_mul_iterative #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 u_lhs,
    input  logic                 u_rhs,
    input  logic [WIDTH-1:0]     lhs,
    input  logic [WIDTH-1:0]     rhs,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   res
);

    localparam int N  = WIDTH / STEP;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH % STEP) != 0 || STEP < 1) begin : g_bad_step
            $error("boa_mul_iterative: WIDTH must be a positive multiple of STEP");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   mcand_sh;   // multiplicand magnitude, pre-shifted to the current digit
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     rem;        // multiplier digits that are still unconsumed
    logic                 neg;

    logic                 sign_l, sign_r;
    logic [WIDTH-1:0]     lhs_mag, rhs_mag;
    logic [2*WIDTH-1:0]   partial, acc_next;
    logic [WIDTH-1:0]     rem_next;
    logic                 last;

    always_comb begin
        sign_l   = !u_lhs && lhs[WIDTH-1];
        sign_r   = !u_rhs && rhs[WIDTH-1];
        // -2^(WIDTH-1) negates to itself. As an unsigned value it is the correct magnitude.
        lhs_mag  = sign_l ? (~lhs + 1'b1) : lhs;
        rhs_mag  = sign_r ? (~rhs + 1'b1) : rhs;
        partial  = mcand_sh * {{(2*WIDTH-STEP){1'b0}}, rem[STEP-1:0]};
        acc_next = acc + partial;
        rem_next = rem >> STEP;
`ifdef BOA_MUL_EARLY_EXIT_EN
        last     = (cnt == CW'(N-1)) || (rem_next == '0);
`else
        last     = (cnt == CW'(N-1));
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            res      <= '0;
            cnt      <= '0;
            mcand_sh <= '0;
            acc      <= '0;
            rem      <= '0;
            neg      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand_sh <= {{WIDTH{1'b0}}, lhs_mag};
                        rem      <= rhs_mag;
                        acc      <= '0;
                        neg      <= sign_l ^ sign_r;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc      <= acc_next;
                    mcand_sh <= mcand_sh << STEP;
                    rem      <= rem_next;
                    cnt      <= cnt + 1'b1;
                    if (last) begin
                        // A zero magnitude negates to zero, so a zero product never becomes nonzero.
                        res   <= neg ? (~acc_next + 1'b1) : acc_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        cnt   <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_boa_mul_iterative.sv
module tb_boa_mul_iterative;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        u_lhs, u_rhs;
    logic [31:0] lhs, rhs;
    logic        busy, done;
    logic [63:0] res;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    boa_mul_iterative #(.WIDTH(32), .STEP(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .u_lhs (u_lhs),
        .u_rhs (u_rhs),
        .lhs   (lhs),
        .rhs   (rhs),
        .busy  (busy),
        .done  (done),
        .res   (res)
    );

    typedef struct {
        logic        ul;
        logic        ur;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    // Reference model: sign- or zero-extend both operands to 64 bits, then multiply modulo 2^64.
    function automatic logic [63:0] ref_mul(logic ul, logic ur, logic [31:0] a, logic [31:0] b);
        logic [63:0] ea, eb;
        ea = ul ? {32'b0, a} : {{32{a[31]}}, a};
        eb = ur ? {32'b0, b} : {{32{b[31]}}, b};
        return ea * eb;
    endfunction

    function automatic int exp_latency(logic ur, logic [31:0] b);
`ifdef BOA_MUL_EARLY_EXIT_EN
        logic [31:0] mag;
        int top;
        mag = (!ur && b[31]) ? (0 - b) : b;
        top = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) top = i + 1;
        return (top < 1) ? 1 : top;
`else
        return 32;
`endif
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    // Drives start for one accept edge, then waits for done with a bound of 100 cycles.
    // lat is the number of edges from the accept edge to the edge that raises done.
    task automatic run_op(input logic ul, input logic ur, input logic [31:0] a,
                          input logic [31:0] b, output logic [63:0] r, output int lat);
        start = 1'b1; u_lhs = ul; u_rhs = ur; lhs = a; rhs = b;
        @(posedge clk); #1;
        start = 1'b0; lhs = $urandom; rhs = $urandom;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        r = res;
    endtask

    vec_t tbl[10];
    logic [63:0] r;
    int lat;
    logic [31:0] ra, rb;
    logic rul, rur;
    logic bad;
    logic [63:0] res_a;

    initial begin
        tbl[0] = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001};
        tbl[1] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001};
        tbl[2] = '{1'b0, 1'b0, 32'h80000000, 32'h80000000, 64'h40000000_00000000};
        tbl[3] = '{1'b0, 1'b1, 32'hFFFFFFFE, 32'hFFFFFFFF, 64'hFFFFFFFE_00000002};
        tbl[4] = '{1'b1, 1'b1, 32'd7,        32'd3,        64'd21};
        tbl[5] = '{1'b0, 1'b0, 32'hFFFFFFFB, 32'd3,        64'hFFFFFFFF_FFFFFFF1};
        tbl[6] = '{1'b0, 1'b0, 32'd0,        32'hFFFFFFFF, 64'd0};
        tbl[7] = '{1'b0, 1'b1, 32'h80000000, 32'd1,        64'hFFFFFFFF_80000000};
        tbl[8] = '{1'b1, 1'b1, 32'h80000000, 32'd2,        64'h00000001_00000000};
        tbl[9] = '{1'b0, 1'b0, 32'h7FFFFFFF, 32'h80000000, 64'hC0000000_80000000};

        rst_n = 1'b0; start = 1'b0; u_lhs = 1'b0; u_rhs = 1'b0; lhs = '0; rhs = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_res", res, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i].ul, tbl[i].ur, tbl[i].a, tbl[i].b, r, lat);
            check($sformatf("tbl%0d_res", i), r, tbl[i].exp);
            check($sformatf("tbl%0d_lat", i), 64'(lat), 64'(exp_latency(tbl[i].ur, tbl[i].b)));
        end

        for (int i = 0; i < 40; i++) begin
            rul = 1'($urandom); rur = 1'($urandom);
            ra = $urandom; rb = $urandom;
            if (i % 8 == 0) rb = rb >> $urandom_range(31, 0);
            run_op(rul, rur, ra, rb, r, lat);
            check($sformatf("rnd%0d_res", i), r, ref_mul(rul, rur, ra, rb));
            check($sformatf("rnd%0d_lat", i), 64'(lat), 64'(exp_latency(rur, rb)));
        end

        // Start while busy is ignored. A start in the done cycle is accepted.
        start = 1'b1; u_lhs = 1'b1; u_rhs = 1'b1; lhs = 32'd1000; rhs = 32'd12345;
        @(posedge clk); #1;
        start = 1'b0;
        bad = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            start = (lat == 4 || lat == 30);
            lhs = 32'hDEADBEEF; rhs = 32'h0BADF00D; u_lhs = 1'b0;
            @(posedge clk); #1;
            lat++;
            if (!done && !busy) bad = 1'b1;
        end
        start = 1'b0;
        check("busy_ign_lat", 64'(lat), 64'd32);
        check("busy_ign_res", res, 64'd12345000);
        check("busy_ign_held", {63'd0, bad}, 64'd0);
        res_a = res;
        start = 1'b1; u_lhs = 1'b1; u_rhs = 1'b1; lhs = 32'd3; rhs = 32'h80000001;
        @(posedge clk); #1;
        start = 1'b0;
        bad = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            if (res !== res_a) bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        check("done_cycle_lat", 64'(lat), 64'd32);
        check("done_cycle_stable", {63'd0, bad}, 64'd0);
        check("done_cycle_res", res, 64'h00000001_80000003);

        // Reset in the middle of an operation aborts it.
        start = 1'b1; lhs = 32'd5; rhs = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_res", res, 64'd0);
        bad = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) bad = 1'b1;
        end
        check("abort_no_done", {63'd0, bad}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
